// File: rtl/dma_transfer_sequencer.sv
// dma_transfer_sequencer
//   Active-cycle sequencer of an 8237A-compatible DMA controller. Accepts the
//   winning channel from the priority block, runs the HRQ/HLDA handshake and
//   walks the SI/S0/S1/S2/S3/SW/S4 transfer states (SC for cascade), driving
//   DACK, AEN, ADSTB, the bus strobes and EOP, and tells the address/count
//   registers when to advance and when a service has ended.
//
// Ports
//   CLK, RESET_N          clock (posedge) / asynchronous active-low reset
//   req_valid, req_grant  pending request and one-hot winning channel
//   ch_mode, ch_xfer      2-bit per-channel mode and transfer type
//   dreq_active           polarity-resolved DREQ per channel
//   HLDA, READY           hold acknowledge, slow-device ready
//   eop_in_n, tc          external EOP (active low), terminal count
//   cmd_disable           controller disable
//   compressed            compressed timing
//   HRQ, dack, AEN, ADSTB hold request, one-hot acknowledge, address controls
//   MEMR_N..IOW_N         active-low bus strobes
//   eop_out_n             active-low EOP driven on the TC transfer
//   upd_strobe, svc_done  advance address/count; service finished
//   svc_ch, busy          channel under service; not idle
module dma_transfer_sequencer #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  req_valid,
    input  logic [NUM_CH-1:0]     req_grant,
    input  logic [2*NUM_CH-1:0]   ch_mode,
    input  logic [2*NUM_CH-1:0]   ch_xfer,
    input  logic [NUM_CH-1:0]     dreq_active,
    input  logic                  HLDA,
    input  logic                  READY,
    input  logic                  eop_in_n,
    input  logic                  tc,
    input  logic                  cmd_disable,
    input  logic                  compressed,
    output logic                  HRQ,
    output logic [NUM_CH-1:0]     dack,
    output logic                  AEN,
    output logic                  ADSTB,
    output logic                  MEMR_N,
    output logic                  MEMW_N,
    output logic                  IOR_N,
    output logic                  IOW_N,
    output logic                  eop_out_n,
    output logic                  upd_strobe,
    output logic                  svc_done,
    output logic [1:0]            svc_ch,
    output logic                  busy
);

    typedef enum logic [2:0] {ST_SI, ST_S0, ST_S1, ST_S2, ST_S3, ST_SW, ST_S4, ST_SC} state_t;
    typedef enum logic [1:0] {MODE_DEMAND, MODE_SINGLE, MODE_BLOCK, MODE_CASCADE} mode_t;
    typedef enum logic [1:0] {XF_VERIFY, XF_WRITE, XF_READ, XF_VERIFY_ALT} xfer_t;

    state_t      state, state_next;
    mode_t       mode_q;
    xfer_t       xfer_q;
    logic        eop_seen;
    logic        eop_hit;
    logic        done_next;
    logic        launch;
    logic [1:0]  grant_idx;
    logic [1:0]  grant_mode;
    logic [1:0]  grant_xfer;
    logic        dreq_sv;
    logic        rd_win, wr_win, is_rd, is_wr;

    // Decode the one-hot grant into an index and that channel's mode/type.
    always_comb begin
        grant_idx  = '0;
        grant_mode = '0;
        grant_xfer = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (req_grant[i]) begin
                grant_idx  = 2'(i);
                grant_mode = ch_mode[2*i +: 2];
                grant_xfer = ch_xfer[2*i +: 2];
            end
        end
    end

    assign dreq_sv = dreq_active[svc_ch];
    assign launch  = (state == ST_SI) && req_valid && !cmd_disable;
    // EOP counts if it was seen anywhere from S1 up to and including this cycle.
    assign eop_hit = eop_seen | ~eop_in_n;

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            ST_SI: if (launch) state_next = ST_S0;
            ST_S0: begin
                if (HLDA)
                    state_next = (mode_q == MODE_CASCADE) ? ST_SC : ST_S1;
                else if (!dreq_sv)
                    state_next = ST_SI;
            end
            ST_SC: if (!dreq_sv) state_next = ST_SI;
            ST_S1: state_next = ST_S2;
            ST_S2: begin
                if (compressed)
                    state_next = READY ? ST_S4 : ST_SW;
                else
                    state_next = ST_S3;
            end
            ST_S3: state_next = READY ? ST_S4 : ST_SW;
            ST_SW: state_next = READY ? ST_S4 : ST_SW;
            ST_S4: begin
                if (tc || eop_hit) begin
                    state_next = ST_SI;
                    done_next  = 1'b1;
                end else if (!HLDA) begin
                    state_next = ST_SI;
                end else begin
                    case (mode_q)
                        MODE_BLOCK:  state_next = ST_S1;
                        MODE_DEMAND: state_next = dreq_sv ? ST_S1 : ST_SI;
                        default:     state_next = ST_SI;
                    endcase
                end
            end
            default: state_next = ST_SI;
        endcase
    end

    assign is_rd  = (xfer_q == XF_READ);
    assign is_wr  = (xfer_q == XF_WRITE);
    assign rd_win = state_next inside {ST_S2, ST_S3, ST_SW, ST_S4};
    // Compressed timing skips S3, so the write strobe joins the read strobe in S2.
    assign wr_win = (state_next inside {ST_S3, ST_SW, ST_S4}) ||
                    ((state_next == ST_S2) && compressed);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_SI;
            svc_ch   <= '0;
            mode_q   <= MODE_DEMAND;
            xfer_q   <= XF_VERIFY;
            eop_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (launch) begin
                svc_ch <= grant_idx;
                mode_q <= mode_t'(grant_mode);
                xfer_q <= xfer_t'(grant_xfer);
            end
            case (state)
                ST_S1:               eop_seen <= ~eop_in_n;
                ST_S2, ST_S3, ST_SW: eop_seen <= eop_hit;
                default:             eop_seen <= eop_seen;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HRQ        <= 1'b0;
            busy       <= 1'b0;
            dack       <= '0;
            AEN        <= 1'b0;
            ADSTB      <= 1'b0;
            MEMR_N     <= 1'b1;
            MEMW_N     <= 1'b1;
            IOR_N      <= 1'b1;
            IOW_N      <= 1'b1;
            eop_out_n  <= 1'b1;
            upd_strobe <= 1'b0;
            svc_done   <= 1'b0;
        end else begin
            HRQ        <= (state_next != ST_SI);
            busy       <= (state_next != ST_SI);
            dack       <= (state_next inside {ST_SC, ST_S2, ST_S3, ST_SW, ST_S4}) ?
                          (NUM_CH'(1) << svc_ch) : '0;
            AEN        <= state_next inside {ST_S1, ST_S2, ST_S3, ST_SW, ST_S4};
            ADSTB      <= (state_next == ST_S1);
            MEMR_N     <= !(is_rd && rd_win);
            IOR_N      <= !(is_wr && rd_win);
            IOW_N      <= !(is_rd && wr_win);
            MEMW_N     <= !(is_wr && wr_win);
            eop_out_n  <= !((state_next == ST_S4) && tc);
            upd_strobe <= (state_next == ST_S4);
            svc_done   <= done_next;
        end
    end

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Bench for dma_transfer_sequencer: services are expanded into a per-cycle
// trace of expected bus phases with matching input stimulus; a compare
// process checks every output every cycle, and directed scenarios pin cycle
// and strobe counts with literal values.
module tb_dma_transfer_sequencer;

    localparam int unsigned NUM_CH = 4;

    typedef enum int {P_SI, P_S0, P_S1, P_S2, P_S3, P_SW, P_S4, P_SC} ph_t;

    typedef struct {
        ph_t        ph;
        logic       rv;
        logic [3:0] grant;
        logic [7:0] mode;
        logic [7:0] xfer;
        logic [3:0] dreq;
        logic       hlda, ready, eopn, tc, dis, comp;
        int         ch;
        int         xt;
        bit         cmp;
        bit         tcx;
        bit         done;
        int         svc;
    } cyc_t;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_grant = '0;
    logic [7:0]  ch_mode = '0;
    logic [7:0]  ch_xfer = '0;
    logic [3:0]  dreq_active = '0;
    logic        HLDA = 1'b0, READY = 1'b1, eop_in_n = 1'b1, tc = 1'b0;
    logic        cmd_disable = 1'b0, compressed = 1'b0;
    logic        HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N;
    logic        eop_out_n, upd_strobe, svc_done, busy;
    logic [3:0]  dack;
    logic [1:0]  svc_ch;
    logic [16:0] obs;

    dma_transfer_sequencer #(.NUM_CH(NUM_CH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_grant(req_grant),
        .ch_mode(ch_mode), .ch_xfer(ch_xfer), .dreq_active(dreq_active), .HLDA(HLDA),
        .READY(READY), .eop_in_n(eop_in_n), .tc(tc), .cmd_disable(cmd_disable),
        .compressed(compressed), .HRQ(HRQ), .dack(dack), .AEN(AEN), .ADSTB(ADSTB),
        .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .eop_out_n(eop_out_n), .upd_strobe(upd_strobe), .svc_done(svc_done),
        .svc_ch(svc_ch), .busy(busy)
    );

    initial forever #5 CLK = ~CLK;

    // hrq,busy,aen,adstb,dack[3:0],memr_n,memw_n,ior_n,iow_n,eop_out_n,upd,done,svc_ch[1:0]
    assign obs = {HRQ, busy, AEN, ADSTB, dack, MEMR_N, MEMW_N, IOR_N, IOW_N,
                  eop_out_n, upd_strobe, svc_done, svc_ch};

    logic [16:0] rst_vec;
    assign rst_vec = {4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'b00};

    int   n_cmp = 0, n_bad = 0, n_cyc = 0;
    cyc_t cur;
    bit   cur_valid = 0;
    cyc_t tr[$];
    int   m_svc = 0, g_ch = 0, g_xfer = 0;
    bit   g_comp = 0, pend_done = 0;
    int   c_hrq, c_aen, c_dack, c_memr, c_memw, c_ior, c_iow, c_eopo, c_upd, c_done;

    function automatic cyc_t rnd_entry(input ph_t ph);
        cyc_t e;
        e.ph = ph;
        e.rv = 1'($urandom); e.grant = 4'($urandom);
        e.mode = 8'($urandom); e.xfer = 8'($urandom); e.dreq = 4'($urandom);
        e.hlda = 1'($urandom); e.ready = 1'($urandom); e.eopn = 1'($urandom);
        e.tc = 1'($urandom); e.dis = 1'($urandom); e.comp = 1'($urandom);
        e.ch = g_ch; e.xt = g_xfer; e.cmp = g_comp; e.tcx = 0; e.done = 0; e.svc = m_svc;
        return e;
    endfunction

    // Expected outputs for a cycle spent in a given bus phase.
    function automatic logic [16:0] exp_vec(input cyc_t e);
        bit act, dk, rdw, wrw, isr, isw;
        logic [3:0] dck;
        act = e.ph inside {P_S1, P_S2, P_S3, P_SW, P_S4};
        dk  = e.ph inside {P_SC, P_S2, P_S3, P_SW, P_S4};
        rdw = e.ph inside {P_S2, P_S3, P_SW, P_S4};
        wrw = (e.ph inside {P_S3, P_SW, P_S4}) || (e.ph == P_S2 && e.cmp);
        isr = (e.xt == 2);
        isw = (e.xt == 1);
        dck = dk ? 4'(1 << e.ch) : 4'b0000;
        return {e.ph != P_SI, e.ph != P_SI, act, e.ph == P_S1, dck,
                !(isr && rdw), !(isw && wrw), !(isw && rdw), !(isr && wrw),
                !(e.ph == P_S4 && e.tcx), e.ph == P_S4, e.done, 2'(e.svc)};
    endfunction

    always @(negedge CLK) begin
        if (cur_valid) begin
            logic [16:0] ev;
            n_cyc++;
            ev = exp_vec(cur);
            n_cmp++;
            if (obs !== ev) begin
                n_bad++;
                $display("FAIL cycle%0d %s: got %b required %b (hrq,busy,aen,adstb,dack,memr,memw,ior,iow,eopo,upd,done,ch)",
                         n_cyc, cur.ph.name(), obs, ev);
            end
            c_hrq  += int'(HRQ);
            c_aen  += int'(AEN);
            c_dack += int'(dack != 4'b0000);
            c_memr += int'(!MEMR_N);
            c_memw += int'(!MEMW_N);
            c_ior  += int'(!IOR_N);
            c_iow  += int'(!IOW_N);
            c_eopo += int'(!eop_out_n);
            c_upd  += int'(upd_strobe);
            c_done += int'(svc_done);
        end
    end

    task automatic clr_cnt();
        c_hrq = 0; c_aen = 0; c_dack = 0; c_memr = 0; c_memw = 0;
        c_ior = 0; c_iow = 0; c_eopo = 0; c_upd = 0; c_done = 0;
    endtask

    task automatic check_lit(input string nm, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic check_vec(input string nm, input logic [16:0] got, input logic [16:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", nm, got, req);
        end
    endtask

    task automatic apply(input cyc_t e);
        req_valid = e.rv; req_grant = e.grant; ch_mode = e.mode; ch_xfer = e.xfer;
        dreq_active = e.dreq; HLDA = e.hlda; READY = e.ready; eop_in_n = e.eopn;
        tc = e.tc; cmd_disable = e.dis; compressed = e.comp;
    endtask

    task automatic push_idle(input int n);
        cyc_t e;
        for (int i = 0; i < n; i++) begin
            e = rnd_entry(P_SI);
            if (e.rv) e.dis = 1'b1;
            e.done = pend_done;
            pend_done = 0;
            tr.push_back(e);
        end
    endtask

    // mode: 0 demand, 1 single, 2 block, 3 cascade. xfer: 1 write, 2 read, else verify.
    // endk: 0 tc on last transfer, 1 eop on last transfer, 2 natural end
    // (single: one transfer, demand: DREQ drops, block: HLDA drops in S4,
    // cascade: DREQ drops), 3 DREQ drops while waiting in S0.
    // ntr: transfers (cascade: SC cycles with DREQ high). wfix/eop_pos < 0: random.
    task automatic gen_service(input int ch, input int mode, input int xfer, input bit comp,
                               input int hd, input int ntr, input int endk,
                               input int eop_pos, input int wfix);
        cyc_t e;
        int   w, len, dpos, ep;
        bit   last, tcl;
        ph_t  ph;
        g_ch = ch; g_xfer = xfer; g_comp = comp;
        e = rnd_entry(P_SI);
        e.rv = 1'b1; e.dis = 1'b0; e.grant = 4'(1 << ch);
        e.mode[2*ch +: 2] = 2'(mode);
        e.xfer[2*ch +: 2] = 2'(xfer);
        e.done = pend_done;
        pend_done = 0;
        tr.push_back(e);
        m_svc = ch;
        if (endk == 3) begin
            e = rnd_entry(P_S0); e.hlda = 1'b0; e.dreq[ch] = 1'b0;
            tr.push_back(e);
            return;
        end
        for (int i = 0; i < hd; i++) begin
            e = rnd_entry(P_S0); e.hlda = 1'b0; e.dreq[ch] = 1'b1; e.comp = comp;
            tr.push_back(e);
        end
        e = rnd_entry(P_S0); e.hlda = 1'b1; e.dreq[ch] = 1'b1; e.comp = comp;
        tr.push_back(e);
        if (mode == 3) begin
            for (int i = 0; i < ntr; i++) begin
                e = rnd_entry(P_SC); e.dreq[ch] = 1'b1;
                tr.push_back(e);
            end
            e = rnd_entry(P_SC); e.dreq[ch] = 1'b0;
            tr.push_back(e);
            return;
        end
        for (int t = 0; t < ntr; t++) begin
            last = (t == ntr - 1);
            w    = (wfix >= 0) ? wfix : int'($urandom_range(0, 2));
            len  = (comp ? 3 : 4) + w;
            dpos = comp ? 1 : 2;
            ep   = (eop_pos >= 0) ? eop_pos : int'($urandom_range(0, len - 1));
            tcl  = last && (endk == 0);
            for (int k = 0; k < len; k++) begin
                if (k == 0)               ph = P_S1;
                else if (k == 1)          ph = P_S2;
                else if (k == len - 1)    ph = P_S4;
                else if (!comp && k == 2) ph = P_S3;
                else                      ph = P_SW;
                e = rnd_entry(ph);
                e.comp = comp; e.tc = tcl; e.tcx = tcl; e.hlda = 1'b1; e.eopn = 1'b1;
                if (k >= dpos && k < dpos + w) e.ready = 1'b0;
                else if (k == dpos + w)        e.ready = 1'b1;
                if (mode == 0) e.dreq[ch] = !(last && endk == 2 && k >= 1);
                if (last && endk == 2 && mode == 2 && k == len - 1) e.hlda = 1'b0;
                if (last && endk == 1 && k == ep) e.eopn = 1'b0;
                tr.push_back(e);
            end
        end
        pend_done = (endk <= 1);
    endtask

    task automatic run_trace();
        cyc_t e;
        while (tr.size() > 0) begin
            e = tr.pop_front();
            @(posedge CLK); #1;
            apply(e);
            cur = e;
            cur_valid = 1;
        end
        @(posedge CLK); #1;
        cur_valid = 0;
    endtask

    initial begin
        cyc_t e;
        clr_cnt();
        repeat (3) @(posedge CLK);
        #1;
        check_vec("reset_state", obs, rst_vec);
        RESET_N = 1'b1;

        // single-mode read, channel 2, HLDA two cycles after HRQ
        clr_cnt(); push_idle(2); gen_service(2, 1, 2, 0, 2, 1, 2, -1, 0); push_idle(2); run_trace();
        check_lit("single_hrq_cycles", c_hrq, 7);
        check_lit("single_memr_low", c_memr, 3);
        check_lit("single_iow_low", c_iow, 2);
        check_lit("single_dack_cycles", c_dack, 3);
        check_lit("single_upd", c_upd, 1);

        // block write, channel 0, compressed, tc on the 3rd transfer
        clr_cnt(); gen_service(0, 2, 1, 1, 0, 3, 0, -1, 0); push_idle(2); run_trace();
        check_lit("block_upd", c_upd, 3);
        check_lit("block_aen_cycles", c_aen, 9);
        check_lit("block_memw_low", c_memw, 6);
        check_lit("block_eop_out", c_eopo, 1);
        check_lit("block_done", c_done, 1);

        // demand read, channel 1, DREQ drops in the 2nd transfer
        clr_cnt(); gen_service(1, 0, 2, 0, 0, 2, 2, -1, 0); push_idle(2); run_trace();
        check_lit("demand_upd", c_upd, 2);
        check_lit("demand_done", c_done, 0);

        // three wait states
        clr_cnt(); gen_service(0, 1, 2, 0, 0, 1, 2, -1, 3); push_idle(2); run_trace();
        check_lit("wait_aen_cycles", c_aen, 7);
        check_lit("wait_memr_low", c_memr, 6);
        check_lit("wait_iow_low", c_iow, 5);

        // cascade, channel 3, DREQ high for 10 cycles after HLDA
        clr_cnt(); gen_service(3, 3, 2, 0, 0, 10, 2, -1, 0); push_idle(2); run_trace();
        check_lit("cascade_dack_cycles", c_dack, 11);
        check_lit("cascade_hrq_cycles", c_hrq, 12);
        check_lit("cascade_aen", c_aen, 0);
        check_lit("cascade_strobes", c_memr + c_memw + c_ior + c_iow, 0);

        // external EOP in S2 of the 2nd block transfer
        clr_cnt(); gen_service(2, 2, 2, 0, 0, 2, 1, 1, 0); push_idle(2); run_trace();
        check_lit("eop_upd", c_upd, 2);
        check_lit("eop_done", c_done, 1);
        check_lit("eop_out_quiet", c_eopo, 0);

        // HLDA withdrawn in S4 of a block service
        clr_cnt(); gen_service(1, 2, 1, 0, 1, 2, 2, -1, -1); push_idle(2); run_trace();
        check_lit("hlda_drop_done", c_done, 0);
        check_lit("hlda_drop_upd", c_upd, 2);

        // randomized services
        for (int s = 0; s < 60; s++) begin
            int ch, md, xf, nt, ek;
            bit cp;
            ch = int'($urandom_range(0, 3));
            md = int'($urandom_range(0, 3));
            xf = int'($urandom_range(0, 3));
            cp = 1'($urandom);
            ek = int'($urandom_range(0, 3));
            if (md == 1)      nt = 1;
            else if (md == 3) nt = int'($urandom_range(0, 5));
            else              nt = int'($urandom_range(1, 4));
            gen_service(ch, md, xf, cp, int'($urandom_range(0, 3)), nt, ek, -1, -1);
            push_idle(int'($urandom_range(1, 3)));
        end
        run_trace();

        // reset asserted while in S2
        push_idle(2);
        gen_service(2, 2, 2, 0, 0, 2, 0, -1, 0);
        while (tr.size() > 0) begin
            e = tr.pop_front();
            @(posedge CLK); #1;
            apply(e);
            cur = e;
            cur_valid = 1;
            if (e.ph == P_S2) break;
        end
        @(negedge CLK); #1;
        cur_valid = 0;
        RESET_N = 1'b0;
        #1;
        check_vec("reset_in_s2", obs, rst_vec);
        tr.delete();
        m_svc = 0;
        pend_done = 0;
        e = rnd_entry(P_SI);
        e.rv = 1'b0;
        apply(e);
        @(posedge CLK); #1;
        check_vec("reset_held", obs, rst_vec);
        RESET_N = 1'b1;
        clr_cnt(); push_idle(1); gen_service(1, 1, 1, 1, 1, 1, 0, -1, -1); push_idle(2); run_trace();
        check_lit("post_reset_upd", c_upd, 1);
        check_lit("post_reset_done", c_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
